unidade_controle_multiciclo: RTL
================================

# unidade_controle_multiciclo

Multicycle control unit for the RISC-V datapath. It decodes the fetched instruction and sequences fetch, decode, execute, memory and write-back. Each cycle it drives the ALU operation code, the operand selects and all register/memory enables. It supports exactly the ALU's instruction set (lh, sh, sub, or, andi, srl, beq) and waits on a memory ready handshake.

## Interface
- LARGURA_CONTADOR, 32: width of the retired-instruction counter.
- LIMITE_ESPERA, 255: max cycles waiting on mem_pronta before abort; 0 disables the timeout.

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high; all state and outputs to reset values
- instrucao  in  32  instruction register contents (stable from DECODIFICA until next fetch)
- zero  in  1  datapath flag: ALU resultado == 0
- mem_pronta  in  1  memory completed the requested read/write this cycle
- operacao_ula  out  4  0000 SOMA, 0001 SUBTRACAO, 0010 AND, 0011 OR, 0100 SRL
- seletor_a  out  2  00 PC, 01 rs1, 10 pc_antigo
- seletor_b  out  2  00 rs2, 01 constant 4, 10 immediate
- le_mem / escreve_mem  out  1 each  memory read / write request
- endereco_de_pc  out  1  memory address = PC (1) or ALU output register (0)
- escreve_ir / escreve_pc  out  1 each  load IR / load PC unconditionally
- escreve_pc_cond  out  1  load PC from ALU output register if zero=1
- escreve_reg  out  1  register file write
- seletor_escrita  out  1  write-back data: 0 ALU output register, 1 memory data (sign-extended half)
- instrucao_invalida  out  1  one-cycle pulse on an unsupported encoding
- erro_memoria  out  1  one-cycle pulse on a mem_pronta timeout
- estado  out  3  current state encoding
- contador_instrucoes  out  LARGURA_CONTADOR  retired instructions, wraps to 0

## Operation
- States: INICIO=0, BUSCA=1, DECODIFICA=2, EXECUTA=3, MEMORIA=4, ESCRITA=5.
- Outputs are Moore-style, decoded from the state and instrucao. Unlisted outputs are 0. Error pulses are registered.
- INICIO: all outputs 0. Goes to BUSCA next cycle.
- BUSCA: le_mem=1, endereco_de_pc=1, seletor_a=00, seletor_b=01, SOMA.
  - escreve_ir and escreve_pc are asserted only in the cycle mem_pronta=1; the FSM then moves to DECODIFICA.
  - Otherwise it holds in BUSCA.
- DECODIFICA (1 cycle): seletor_a=10, seletor_b=10, SOMA (branch target precompute).
  - Supported encoding -> EXECUTA.
  - Otherwise pulse instrucao_invalida -> BUSCA; the counter does not increment.
- Supported encodings (opcode / funct3 / funct7):
  - lh 0000011/001
  - sh 0100011/001
  - sub 0110011/000/0100000
  - or 0110011/110/0000000
  - srl 0110011/101/0000000
  - andi 0010011/111
  - beq 1100011/000
- EXECUTA:
  - lh/sh: seletor_a=01, seletor_b=10, SOMA -> MEMORIA.
  - sub/or/srl: seletor_a=01, seletor_b=00, op SUBTRACAO/OR/SRL -> ESCRITA.
  - andi: seletor_a=01, seletor_b=10, AND -> ESCRITA.
  - beq: seletor_a=01, seletor_b=00, SUBTRACAO, escreve_pc_cond=1 -> BUSCA; retires.
- MEMORIA: endereco_de_pc=0.
  - lh: le_mem=1 until mem_pronta, then ESCRITA.
  - sh: escreve_mem=1 until mem_pronta, then BUSCA; retires.
- ESCRITA: escreve_reg=1, seletor_escrita=1 for lh, else 0 -> BUSCA; retires.
- Retire: contador_instrucoes += 1 on the transition into BUSCA from a completing state. Modulo 2^LARGURA_CONTADOR.
- Timeout: a wait counter runs in BUSCA and MEMORIA while mem_pronta=0 and clears on each state change.
  - If it reaches LIMITE_ESPERA (nonzero): pulse erro_memoria, drop all requests, go to BUSCA; no retire.
  - A BUSCA timeout re-enters BUSCA with the counter cleared.

## Timing
- Reset (async assert, sync effect on release): estado=INICIO, all outputs 0, counters 0.
- Cycles with mem_pronta already high on each request:
  - beq: 3 (BUSCA, DEC, EXE)
  - sub/or/srl/andi: 4
  - sh: 4
  - lh: 5
- Each wait cycle adds one cycle.
- Requests (le_mem/escreve_mem) stay asserted and stable until the mem_pronta cycle. They drop the next cycle.
- mem_pronta high outside BUSCA/MEMORIA is ignored.
- Reset mid-instruction: immediate return to INICIO, requests drop asynchronously, no retire.
- Error pulses last exactly 1 cycle, asserted in the cycle after the detecting state.

## Test plan
- Reset released, mem_pronta=1, instrucao=sub x3,x1,x2 (0x402081B3) -> estados 0,1,2,3,5,1. In EXECUTA operacao_ula=0001, seletor_b=00. escreve_reg=1 in ESCRITA. contador_instrucoes=1.
- lh x6,4(x0) (0x00401303), mem_pronta low 3 cycles in MEMORIA -> le_mem held 4 cycles. Then ESCRITA with seletor_escrita=1. Total 8 cycles.
- beq x6,x1 (0x00130463), zero=1 -> EXECUTA asserts escreve_pc_cond=1 with SUBTRACAO. Returns to BUSCA after 3 cycles; counter increments.
- andi (0x00707093), or (0x0020E233), srl funct7=0 (0x0010D2B3) -> operacao_ula 0010, 0011, 0100 in EXECUTA.
- instrucao=0x00000013 (addi) -> instrucao_invalida pulses once, back to BUSCA, counter unchanged.
- LIMITE_ESPERA=4, sh (0x00601223) with mem_pronta stuck 0 in MEMORIA -> erro_memoria pulse, escreve_mem drops, then BUSCA. Reset asserted mid-MEMORIA forces estado=0 immediately.

Source files
------------

// File: rtl/unidade_controle_multiciclo_if.sv
`default_nettype none
// ============================================================================
// Module      : unidade_controle_multiciclo_if
// Description : Control-unit <-> datapath/memory bundle (instruction, flags,
//               memory handshake and every control strobe).
// Revision    : 1.0 - initial release
// ============================================================================
interface unidade_controle_multiciclo_if;
    logic [31:0] instrucao;
    logic        zero;
    logic        mem_pronta;
    logic [3:0]  operacao_ula;
    logic [1:0]  seletor_a;
    logic [1:0]  seletor_b;
    logic        le_mem;
    logic        escreve_mem;
    logic        endereco_de_pc;
    logic        escreve_ir;
    logic        escreve_pc;
    logic        escreve_pc_cond;
    logic        escreve_reg;
    logic        seletor_escrita;

    modport master (
        input  instrucao, zero, mem_pronta,
        output operacao_ula, seletor_a, seletor_b, le_mem, escreve_mem,
               endereco_de_pc, escreve_ir, escreve_pc, escreve_pc_cond,
               escreve_reg, seletor_escrita
    );

    modport slave (
        output instrucao, zero, mem_pronta,
        input  operacao_ula, seletor_a, seletor_b, le_mem, escreve_mem,
               endereco_de_pc, escreve_ir, escreve_pc, escreve_pc_cond,
               escreve_reg, seletor_escrita
    );
endinterface
`default_nettype wire

// File: rtl/unidade_controle_multiciclo.sv
`default_nettype none
// ============================================================================
// Module      : unidade_controle_multiciclo
// Description : Multicycle RISC-V control FSM (lh, sh, sub, or, andi, srl, beq)
//               with memory-ready handshake, wait timeout and retire counter.
// Revision    : 1.0 - initial release
// ============================================================================
module unidade_controle_multiciclo #(
    parameter int LARGURA_CONTADOR = 32,
    parameter int LIMITE_ESPERA    = 255
) (
    input  wire logic                        clock,
    input  wire logic                        reset,
    unidade_controle_multiciclo_if.master    bus,
    output logic                             instrucao_invalida,
    output logic                             erro_memoria,
    output logic [2:0]                       estado,
    output logic [LARGURA_CONTADOR-1:0]      contador_instrucoes
);
    localparam int ESPERA_W = (LIMITE_ESPERA > 0) ? $clog2(LIMITE_ESPERA + 1) : 1;

    localparam logic [3:0] C_SOMA = 4'b0000;
    localparam logic [3:0] C_SUB  = 4'b0001;
    localparam logic [3:0] C_AND  = 4'b0010;
    localparam logic [3:0] C_OR   = 4'b0011;
    localparam logic [3:0] C_SRL  = 4'b0100;

    typedef enum logic [2:0] {
        INICIO     = 3'd0,
        BUSCA      = 3'd1,
        DECODIFICA = 3'd2,
        EXECUTA    = 3'd3,
        MEMORIA    = 3'd4,
        ESCRITA    = 3'd5
    } estado_t;

    estado_t                     estado_q, estado_d;
    logic [ESPERA_W-1:0]         espera_q, espera_d;
    logic [LARGURA_CONTADOR-1:0] contador_q, contador_d;
    logic                        invalida_q, invalida_d;
    logic                        erro_q, erro_d;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic w_eh_lh, w_eh_sh, w_eh_sub, w_eh_or, w_eh_srl, w_eh_andi, w_eh_beq;
    logic w_suportada, w_esperando, w_timeout;

    assign w_opcode  = bus.instrucao[6:0];
    assign w_funct3  = bus.instrucao[14:12];
    assign w_funct7  = bus.instrucao[31:25];
    assign w_eh_lh   = (w_opcode == 7'b0000011) && (w_funct3 == 3'b001);
    assign w_eh_sh   = (w_opcode == 7'b0100011) && (w_funct3 == 3'b001);
    assign w_eh_sub  = (w_opcode == 7'b0110011) && (w_funct3 == 3'b000) && (w_funct7 == 7'b0100000);
    assign w_eh_or   = (w_opcode == 7'b0110011) && (w_funct3 == 3'b110) && (w_funct7 == 7'b0000000);
    assign w_eh_srl  = (w_opcode == 7'b0110011) && (w_funct3 == 3'b101) && (w_funct7 == 7'b0000000);
    assign w_eh_andi = (w_opcode == 7'b0010011) && (w_funct3 == 3'b111);
    assign w_eh_beq  = (w_opcode == 7'b1100011) && (w_funct3 == 3'b000);
    assign w_suportada = w_eh_lh | w_eh_sh | w_eh_sub | w_eh_or | w_eh_srl | w_eh_andi | w_eh_beq;

    // Timeout fires in the cycle the wait count has reached the limit; requests are suppressed then.
    assign w_esperando = ((estado_q == BUSCA) || (estado_q == MEMORIA)) && !bus.mem_pronta;
    assign w_timeout   = (LIMITE_ESPERA != 0) && w_esperando &&
                         (espera_q == ESPERA_W'(LIMITE_ESPERA));

    always_comb begin
        estado_d            = estado_q;
        espera_d            = espera_q;
        contador_d          = contador_q;
        invalida_d          = 1'b0;
        erro_d              = 1'b0;
        bus.operacao_ula    = C_SOMA;
        bus.seletor_a       = 2'b00;
        bus.seletor_b       = 2'b00;
        bus.le_mem          = 1'b0;
        bus.escreve_mem     = 1'b0;
        bus.endereco_de_pc  = 1'b0;
        bus.escreve_ir      = 1'b0;
        bus.escreve_pc      = 1'b0;
        bus.escreve_pc_cond = 1'b0;
        bus.escreve_reg     = 1'b0;
        bus.seletor_escrita = 1'b0;

        case (estado_q)
            INICIO: estado_d = BUSCA;
            BUSCA: begin
                bus.seletor_b = 2'b01;
                if (w_timeout) begin
                    erro_d = 1'b1;
                end else begin
                    bus.le_mem         = 1'b1;
                    bus.endereco_de_pc = 1'b1;
                    if (bus.mem_pronta) begin
                        bus.escreve_ir = 1'b1;
                        bus.escreve_pc = 1'b1;
                        estado_d       = DECODIFICA;
                    end
                end
            end
            DECODIFICA: begin
                bus.seletor_a = 2'b10;
                bus.seletor_b = 2'b10;
                if (w_suportada) begin
                    estado_d = EXECUTA;
                end else begin
                    invalida_d = 1'b1;
                    estado_d   = BUSCA;
                end
            end
            EXECUTA: begin
                bus.seletor_a = 2'b01;
                estado_d      = ESCRITA;
                if (w_eh_lh || w_eh_sh) begin
                    bus.seletor_b = 2'b10;
                    estado_d      = MEMORIA;
                end else if (w_eh_sub) begin
                    bus.operacao_ula = C_SUB;
                end else if (w_eh_or) begin
                    bus.operacao_ula = C_OR;
                end else if (w_eh_srl) begin
                    bus.operacao_ula = C_SRL;
                end else if (w_eh_andi) begin
                    bus.seletor_b    = 2'b10;
                    bus.operacao_ula = C_AND;
                end else if (w_eh_beq) begin
                    bus.operacao_ula    = C_SUB;
                    bus.escreve_pc_cond = 1'b1;
                    estado_d            = BUSCA;
                    contador_d          = contador_q + LARGURA_CONTADOR'(1);
                end else begin
                    estado_d = BUSCA;
                end
            end
            MEMORIA: begin
                if (w_timeout) begin
                    erro_d   = 1'b1;
                    estado_d = BUSCA;
                end else if (w_eh_lh) begin
                    bus.le_mem = 1'b1;
                    if (bus.mem_pronta) estado_d = ESCRITA;
                end else if (w_eh_sh) begin
                    bus.escreve_mem = 1'b1;
                    if (bus.mem_pronta) begin
                        estado_d   = BUSCA;
                        contador_d = contador_q + LARGURA_CONTADOR'(1);
                    end
                end else begin
                    estado_d = BUSCA;
                end
            end
            ESCRITA: begin
                bus.escreve_reg     = 1'b1;
                bus.seletor_escrita = w_eh_lh;
                estado_d            = BUSCA;
                contador_d          = contador_q + LARGURA_CONTADOR'(1);
            end
            default: estado_d = INICIO;
        endcase

        if ((LIMITE_ESPERA != 0) && w_esperando && !w_timeout)
            espera_d = espera_q + 1'b1;
        if ((estado_d != estado_q) || w_timeout)
            espera_d = '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q   <= INICIO;
            espera_q   <= '0;
            contador_q <= '0;
            invalida_q <= 1'b0;
            erro_q     <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            espera_q   <= espera_d;
            contador_q <= contador_d;
            invalida_q <= invalida_d;
            erro_q     <= erro_d;
        end
    end

    assign estado              = estado_q;
    assign contador_instrucoes = contador_q;
    assign instrucao_invalida  = invalida_q;
    assign erro_memoria        = erro_q;
endmodule
`default_nettype wire
